// File: rtl/mvm_pkg.sv
// Shared constants, streamer state type and narrowing helper for the MVM datapath.
package mvm_pkg;

    localparam int DEF_MATRIX_ROWS = 6;
    localparam int DEF_SHARED_DIM  = 3;
    localparam int DEF_WIDTH       = 8;
    localparam int DEF_ACC_WIDTH   = DEF_SHARED_DIM * DEF_WIDTH;
    localparam int DEF_OUT_WIDTH   = 8;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } stream_state_e;

    // Clamp a sign-extended value into the signed range of an out_w-bit
    // number. The caller keeps the low out_w bits of the result.
    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int unsigned out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/mvm_saturate.sv
// Combinational ACC_WIDTH -> OUT_WIDTH narrower: signed saturation or plain truncation.
module mvm_saturate
    import mvm_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH,
    parameter int SATURATE  = 1
) (
    input  logic [ACC_WIDTH-1:0] acc,
    output logic [OUT_WIDTH-1:0] narrowed
);

    generate
        if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
            assign narrowed = acc;
        end else if (SATURATE != 0) begin : g_sat
            logic [63:0] clamped;
            logic        unused_hi;
            // Sign-extend to the helper's working width, clamp, keep the low bits.
            always_comb clamped = sat_clamp(64'($signed(acc)), OUT_WIDTH);
            assign narrowed  = clamped[OUT_WIDTH-1:0];
            assign unused_hi = ^clamped[63:OUT_WIDTH];
        end else begin : g_trunc
            logic unused_hi;
            assign narrowed  = acc[OUT_WIDTH-1:0];
            assign unused_hi = ^acc[ACC_WIDTH-1:OUT_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/mvm_result_streamer.sv
// Captures an MVM result vector and streams its narrowed elements one per beat.
module mvm_result_streamer
    import mvm_pkg::*;
#(
    parameter int MATRIX_ROWS = DEF_MATRIX_ROWS,
    parameter int ACC_WIDTH   = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH   = DEF_OUT_WIDTH,
    parameter int SATURATE    = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             result_valid,
    input  logic [MATRIX_ROWS*ACC_WIDTH-1:0] result_vector,
    output logic                             result_ready,
    output logic [OUT_WIDTH-1:0]             out_data,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic                             out_last,
    output logic [$clog2(MATRIX_ROWS)-1:0]   out_index,
    output logic                             busy,
    output logic                             drop
);

    localparam int IDX_W = $clog2(MATRIX_ROWS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MATRIX_ROWS - 1);

    stream_state_e state_q, state_d;

    logic [MATRIX_ROWS-1:0][ACC_WIDTH-1:0] cap_q;
    logic [MATRIX_ROWS-1:0][ACC_WIDTH-1:0] rv_elems;
    logic [IDX_W-1:0]                      idx_d;
    logic                                  valid_d;
    logic                                  cap_load;
    logic                                  upd_data;
    logic                                  drop_d;
    logic [ACC_WIDTH-1:0]                  sel_elem;
    logic [OUT_WIDTH-1:0]                  narrowed;

    assign rv_elems     = result_vector;
    assign result_ready = (state_q == IDLE);

    // One narrower, fed by whichever element is about to be presented.
    mvm_saturate #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SATURATE  (SATURATE)
    ) u_sat (
        .acc      (sel_elem),
        .narrowed (narrowed)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next state, next index and element select. On capture the element comes
    // straight from the input bus since the capture register is not loaded yet.
    always_comb begin
        state_d  = state_q;
        idx_d    = out_index;
        valid_d  = out_valid;
        cap_load = 1'b0;
        upd_data = 1'b0;
        drop_d   = 1'b0;
        sel_elem = cap_q[0];
        case (state_q)
            IDLE: begin
                if (result_valid) begin
                    state_d  = STREAM;
                    cap_load = 1'b1;
                    valid_d  = 1'b1;
                    idx_d    = '0;
                    upd_data = 1'b1;
                    sel_elem = rv_elems[0];
                end
            end
            STREAM: begin
                drop_d = result_valid;
                if (out_valid && out_ready) begin
                    if (out_index == LAST_IDX) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        idx_d   = '0;
                    end else begin
                        idx_d    = out_index + 1'b1;
                        upd_data = 1'b1;
                        sel_elem = cap_q[idx_d];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture register and registered stream outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_index <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            drop      <= 1'b0;
        end else begin
            if (cap_load)
                cap_q <= rv_elems;
            if (upd_data)
                out_data <= narrowed;
            out_valid <= valid_d;
            out_index <= idx_d;
            out_last  <= valid_d && (idx_d == LAST_IDX);
            busy      <= (state_d == STREAM);
            drop      <= drop_d;
        end
    end

endmodule
